// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: single-clock N:1 AXI-Stream packet multiplexer.
// Round-robin arbitration per packet (grant held until tlast), per-source
// enable/flush, source-index sideband on m_tdest, one output register.
// Optional per-source packet/drop statistics: define AXIS_ARB_STATS_EN.
module axis_packet_arbiter #(
  parameter int  NUM_SOURCES = 4,
  parameter int  DATA_WIDTH  = 32,
  parameter int  USER_WIDTH  = 1,
  parameter int  COUNT_WIDTH = 16,
  localparam int SEL_WIDTH   = ($clog2(NUM_SOURCES) > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clk,
  input  logic                              arst,
  input  logic [NUM_SOURCES-1:0]            srcEnable,
  input  logic [NUM_SOURCES-1:0]            s_tvalid,
  output logic [NUM_SOURCES-1:0]            s_tready,
  input  logic [NUM_SOURCES-1:0]            s_tlast,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES*USER_WIDTH-1:0] s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [USER_WIDTH-1:0]             m_tuser,
  output logic [SEL_WIDTH-1:0]              m_tdest,
  output logic                              busy
`ifdef AXIS_ARB_STATS_EN
  ,
  input  logic                               statsClear,
  output logic [NUM_SOURCES*COUNT_WIDTH-1:0] packetCount,
  output logic [NUM_SOURCES*COUNT_WIDTH-1:0] dropCount
`endif
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
  logic [USER_WIDTH-1:0]  m_tuser_q, m_tuser_d;
  logic [SEL_WIDTH-1:0]   m_tdest_q, m_tdest_d;

  logic                   o_accept;
  logic                   beat_xfer;
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] s_tready_c;
  logic [NUM_SOURCES-1:0] flush_ready;
  logic [SEL_WIDTH-1:0]   pick;
  logic                   found;

  assign o_accept = !m_tvalid_q || m_tready;
  assign req      = s_tvalid & srcEnable;

  // Round-robin search: first requesting source after the last granted one
  always_comb begin : arb_search
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = last_grant_q;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_SOURCES;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = SEL_WIDTH'(idx);
      end
    end
  end

  // Next-state, handshake and output-register load logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    m_tdata_d    = m_tdata_q;
    m_tuser_d    = m_tuser_q;
    m_tdest_d    = m_tdest_q;
    s_tready_c   = '0;
    flush_ready  = '0;
    beat_xfer    = 1'b0;

    // Disabled sources drain freely unless they own the current packet
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!srcEnable[i] && !(state_q == ST_LOCKED && grant_q == SEL_WIDTH'(i))) begin
        flush_ready[i] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // Arbitration cycle: no beat moves, grant takes effect next cycle
        if (found) begin
          state_d = ST_LOCKED;
          grant_d = pick;
        end
      end
      ST_LOCKED: begin
        s_tready_c[grant_q] = o_accept;
        beat_xfer           = s_tvalid[grant_q] && o_accept;
        if (beat_xfer && s_tlast[grant_q]) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (o_accept) begin
      m_tvalid_d = beat_xfer;
      if (beat_xfer) begin
        m_tlast_d = s_tlast[grant_q];
        m_tdata_d = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_tuser_d = s_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
        m_tdest_d = grant_q;
      end
    end
  end

  // Arbiter state and output register; reset points the pointer so source 0 wins first
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= SEL_WIDTH'(NUM_SOURCES - 1);
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tuser_q    <= '0;
      m_tdest_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tdata_q    <= m_tdata_d;
      m_tuser_q    <= m_tuser_d;
      m_tdest_q    <= m_tdest_d;
    end
  end

  // Ready is forced low the moment reset asserts, not a cycle later
  assign s_tready = arst ? '0 : (s_tready_c | flush_ready);
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdata  = m_tdata_q;
  assign m_tuser  = m_tuser_q;
  assign m_tdest  = m_tdest_q;
  assign busy     = (state_q == ST_LOCKED);

`ifdef AXIS_ARB_STATS_EN
  logic [COUNT_WIDTH-1:0] pkt_cnt_q  [NUM_SOURCES];
  logic [COUNT_WIDTH-1:0] pkt_cnt_d  [NUM_SOURCES];
  logic [COUNT_WIDTH-1:0] drop_cnt_q [NUM_SOURCES];
  logic [COUNT_WIDTH-1:0] drop_cnt_d [NUM_SOURCES];

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Forwarded packets count at the register load of tlast; flushed ones at their tlast beat
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      pkt_cnt_d[i]  = pkt_cnt_q[i];
      drop_cnt_d[i] = drop_cnt_q[i];
      if (statsClear) begin
        pkt_cnt_d[i]  = '0;
        drop_cnt_d[i] = '0;
      end else begin
        if (beat_xfer && s_tlast[i] && grant_q == SEL_WIDTH'(i)) begin
          pkt_cnt_d[i] = sat_inc(pkt_cnt_q[i]);
        end
        if (flush_ready[i] && s_tvalid[i] && s_tlast[i]) begin
          drop_cnt_d[i] = sat_inc(drop_cnt_q[i]);
        end
      end
    end
  end

  // Statistics counter registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        pkt_cnt_q[i]  <= '0;
        drop_cnt_q[i] <= '0;
      end
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_stats_out
    assign packetCount[g*COUNT_WIDTH +: COUNT_WIDTH] = pkt_cnt_q[g];
    assign dropCount[g*COUNT_WIDTH +: COUNT_WIDTH]   = drop_cnt_q[g];
  end
`else
  // Keeps COUNT_WIDTH referenced in builds without statistics
  logic [31:0] cfg_unused;
  assign cfg_unused = COUNT_WIDTH;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Testbench for axis_packet_arbiter: IDLE ready table plus packet sequences
// checked against a scoreboard of expected output beats.
module tb_axis_packet_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int UW = 1;

  logic            clk = 1'b0;
  logic            arst;
  logic [NS-1:0]   srcEnable, s_tvalid, s_tready, s_tlast;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*UW-1:0] s_tuser;
  logic            m_tvalid, m_tready, m_tlast, busy;
  logic [DW-1:0]   m_tdata;
  logic [UW-1:0]   m_tuser;
  logic [1:0]      m_tdest;
`ifdef AXIS_ARB_STATS_EN
  localparam int CW = 16;
  logic            statsClear;
  logic [NS*CW-1:0] packetCount, dropCount;
`endif

  always #5 clk = ~clk;

  axis_packet_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW), .USER_WIDTH(UW), .COUNT_WIDTH(16)) dut (
    .clk(clk), .arst(arst), .srcEnable(srcEnable),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tdest(m_tdest), .busy(busy)
`ifdef AXIS_ARB_STATS_EN
    , .statsClear(statsClear), .packetCount(packetCount), .dropCount(dropCount)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
    logic [1:0]    dest;
  } exp_t;

  typedef struct packed {
    logic [NS-1:0] en;
    logic [NS-1:0] vld;
    logic [NS-1:0] rdy;
  } vec_t;

  beat_t      src_mem [NS][64];
  int         src_head [NS];
  int         src_tail [NS];
  exp_t       exp_q[$];
  int         out_cyc[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         pkt_id  = 0;
  bit         rdy_rand = 1'b0;
  logic [NS-1:0] chk_flush = '0;
  bit         held_vld = 1'b0;
  exp_t       held;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

`ifdef AXIS_ARB_STATS_EN
  function automatic logic [CW-1:0] pcnt(input int i);
    return packetCount[i*CW +: CW];
  endfunction
  function automatic logic [CW-1:0] dcnt(input int i);
    return dropCount[i*CW +: CW];
  endfunction
`endif

  task automatic add_packet(input int src, input int len, input bit fwd);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = {8'(src), 8'(pkt_id), 16'(b)};
      bt.user = UW'(b & 1);
      bt.last = (b == len - 1);
      src_mem[src][src_tail[src]] = bt;
      src_tail[src]++;
      if (fwd) exp_q.push_back({bt.data, bt.user, bt.last, 2'(src)});
    end
    pkt_id++;
  endtask

  task automatic drive();
    beat_t bt;
    for (int i = 0; i < NS; i++) begin
      if (src_head[i] < src_tail[i]) begin
        bt = src_mem[i][src_head[i]];
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = bt.last;
        s_tdata[i*DW +: DW] = bt.data;
        s_tuser[i*UW +: UW] = bt.user;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tuser[i*UW +: UW] = '0;
      end
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (src_head[i] < src_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_sources();
    for (int i = 0; i < NS; i++) src_head[i] = src_tail[i];
  endtask

  // One clock: sample at negedge, apply handshakes and new stimulus just after posedge
  task automatic cycle();
    logic [NS-1:0] fire;
    exp_t got, e;
    @(negedge clk);
    fire = s_tvalid & s_tready;
    for (int i = 0; i < NS; i++) begin
      if (chk_flush[i] && s_tvalid[i]) check("flush_ready", 64'(s_tready[i]), 64'd1);
    end
    got = {m_tdata, m_tuser, m_tlast, m_tdest};
    if (held_vld) begin
      n_tests++;
      if (!m_tvalid || got !== held) begin
        n_fail++;
        $display("FAIL stall_hold: got vld=%b %h expected vld=1 %h", m_tvalid, got, held);
      end
    end
    held_vld = m_tvalid && !m_tready;
    held     = got;
    if (m_tvalid && m_tready) begin
      out_cyc.push_back(cyc);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data=%h dest=%0d expected none", m_tdata, m_tdest);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL beat: got data=%h user=%b last=%b dest=%0d expected data=%h user=%b last=%b dest=%0d",
                   got.data, got.user, got.last, got.dest, e.data, e.user, e.last, e.dest);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NS; i++) if (fire[i]) src_head[i]++;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    drive();
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (!(all_empty() && exp_q.size() == 0 && !m_tvalid) && n < max_cyc) begin
      cycle();
      n++;
    end
    n_tests++;
    if (n >= max_cyc) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
      exp_q.delete();
      clear_sources();
      drive();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   t0;
    int   h0;
    int   n;
    vecs[0] = {4'b1111, 4'b0000, 4'b0000};
    vecs[1] = {4'b0000, 4'b0000, 4'b1111};
    vecs[2] = {4'b1011, 4'b0100, 4'b0100};
    vecs[3] = {4'b0110, 4'b1001, 4'b1001};
    vecs[4] = {4'b1110, 4'b0001, 4'b0001};
    vecs[5] = {4'b0101, 4'b1010, 4'b1010};
    vecs[6] = {4'b1111, 4'b0000, 4'b0000};

    arst = 1'b1; srcEnable = '0; s_tvalid = '0; s_tlast = '0;
    s_tdata = '0; s_tuser = '0; m_tready = 1'b1;
`ifdef AXIS_ARB_STATS_EN
    statsClear = 1'b0;
`endif
    for (int i = 0; i < NS; i++) begin src_head[i] = 0; src_tail[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    // Reset state; sources disabled so only reset keeps s_tready low
    check("rst_m_tvalid", 64'(m_tvalid), 0);
    check("rst_m_tlast", 64'(m_tlast), 0);
    check("rst_m_tdata", 64'(m_tdata), 0);
    check("rst_m_tuser", 64'(m_tuser), 0);
    check("rst_m_tdest", 64'(m_tdest), 0);
    check("rst_s_tready", 64'(s_tready), 0);
    check("rst_busy", 64'(busy), 0);
    arst = 1'b0;
    srcEnable = '1;
    @(posedge clk);
    #1;

    // IDLE ready table: enabled sources not ready, disabled ones flush
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      srcEnable = vecs[k].en;
      s_tvalid  = vecs[k].vld;
      #1;
      check("idle_s_tready", 64'(s_tready), 64'(vecs[k].rdy));
      check("idle_busy", 64'(busy), 0);
      @(posedge clk);
      #1;
      s_tvalid = '0;
    end
    srcEnable = '1;

    // All four sources, one 3-beat packet each
    for (int s = 0; s < NS; s++) add_packet(s, 3, 1'b1);
    out_cyc.delete();
    t0 = cyc;
    drive();
    wait_drain(80);
    check("t1_beats", 64'(out_cyc.size()), 12);
    for (int k = 0; k < out_cyc.size() && k < 12; k++)
      check("t1_cycle", 64'(out_cyc[k] - t0), 64'(2 + 4 * (k / 3) + k % 3));

    // Source 2 alone, back-to-back 2-beat packets
    for (int p = 0; p < 3; p++) add_packet(2, 2, 1'b1);
    out_cyc.delete();
    t0 = cyc;
    drive();
    wait_drain(60);
    check("t2_beats", 64'(out_cyc.size()), 6);
    for (int k = 0; k < out_cyc.size() && k < 6; k++)
      check("t2_cycle", 64'(out_cyc[k] - t0), 64'(2 + 3 * (k / 2) + k % 2));

    // Random backpressure, sources 3 and 0 (pointer now after 2, so 3 first)
    rdy_rand = 1'b1;
    add_packet(3, 5, 1'b1); add_packet(0, 5, 1'b1);
    add_packet(3, 5, 1'b1); add_packet(0, 5, 1'b1);
    out_cyc.delete();
    drive();
    wait_drain(400);
    rdy_rand = 1'b0;
    m_tready = 1'b1;
    check("t3_beats", 64'(out_cyc.size()), 20);

    // Source 2 disabled and flushed while 1, 3, 0 forward normally
`ifdef AXIS_ARB_STATS_EN
    statsClear = 1'b1;
    @(posedge clk);
    #1;
    statsClear = 1'b0;
`endif
    srcEnable = 4'b1011;
    chk_flush = 4'b0100;
    for (int p = 0; p < 4; p++) add_packet(2, 3, 1'b0);
    add_packet(1, 2, 1'b1); add_packet(3, 2, 1'b1); add_packet(0, 2, 1'b1);
    out_cyc.delete();
    drive();
    wait_drain(80);
    chk_flush = '0;
    check("t4_beats", 64'(out_cyc.size()), 6);
`ifdef AXIS_ARB_STATS_EN
    check("t4_drop2", 64'(dcnt(2)), 4);
    check("t4_pkt2", 64'(pcnt(2)), 0);
    check("t4_pkt0", 64'(pcnt(0)), 1);
`endif
    srcEnable = '1;

    // Source 1 disabled during its 2nd beat: packet completes, next one flushed
    h0 = src_head[1];
    add_packet(1, 4, 1'b1);
    add_packet(1, 4, 1'b0);
    out_cyc.delete();
    drive();
    n = 0;
    while (src_head[1] < h0 + 1 && n < 20) begin cycle(); n++; end
    check("t5_first_beat_bound", 64'(n < 20), 1);
    srcEnable[1] = 1'b0;
    wait_drain(60);
    check("t5_beats", 64'(out_cyc.size()), 4);
`ifdef AXIS_ARB_STATS_EN
    check("t5_pkt1", 64'(pcnt(1)), 2);
    check("t5_drop1", 64'(dcnt(1)), 1);
`endif
    srcEnable = '1;

    // Reset in the middle of a source-2 packet
    add_packet(2, 6, 1'b1);
    out_cyc.delete();
    drive();
    n = 0;
    while (out_cyc.size() < 2 && n < 20) begin cycle(); n++; end
    check("t6_mid_bound", 64'(n < 20), 1);
    check("t6_busy_mid", 64'(busy), 1);
    srcEnable = 4'b0111;
    arst = 1'b1;
    #1;
    check("t6_rst_m_tvalid", 64'(m_tvalid), 0);
    check("t6_rst_s_tready", 64'(s_tready), 0);
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_m_tdata", 64'(m_tdata), 0);
`ifdef AXIS_ARB_STATS_EN
    check("t6_rst_pkt1", 64'(pcnt(1)), 0);
    check("t6_rst_drop2", 64'(dcnt(2)), 0);
`endif
    exp_q.delete();
    clear_sources();
    drive();
    held_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    srcEnable = '1;
    add_packet(0, 2, 1'b1);
    add_packet(2, 2, 1'b1);
    out_cyc.delete();
    t0 = cyc;
    drive();
    wait_drain(60);
    check("t6_beats", 64'(out_cyc.size()), 4);
    if (out_cyc.size() > 0) check("t6_first_latency", 64'(out_cyc[0] - t0), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
